// File: rtl/muldiv_unit.sv
// Multicycle radix-2 multiply/divide unit with start/busy/done handshake and sticky divide-by-zero flag.
// Optional macro MULDIV_UNSIGNED_EN enables op[1] as the unsigned-mode select; otherwise all operations are signed.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_div_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  // state | meaning
  // IDLE  | waiting for start; operands latched on acceptance
  // PREP  | take magnitudes, record result signs, detect divide by zero
  // RUN   | one radix-2 shift-add / shift-subtract step per cycle
  // FIX   | sign-correct, write hi/lo, raise done
  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_is_div;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic               r_dz;
  logic               r_done;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_step;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

`ifdef MULDIV_UNSIGNED_EN
  logic r_uns;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_uns <= 1'b0;
    else if (r_state == S_IDLE && i_start) r_uns <= i_op[1];
  end
  assign w_signed = ~r_uns;
`else
  logic w_unused_op;
  assign w_unused_op = i_op[1];
  assign w_signed    = 1'b1;
`endif

  assign w_a_neg = w_signed & r_a[WIDTH-1];
  assign w_b_neg = w_signed & r_b[WIDTH-1];
  assign w_mag_a = w_a_neg ? -r_a : r_a;
  assign w_mag_b = w_b_neg ? -r_b : r_b;

  // Multiply: r_acc = {partial product, remaining multiplier bits}, multiplicand magnitude in r_a.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_a : '0)};
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: r_acc = {remainder, dividend/quotient}, divisor magnitude in r_b.
  assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_b};
  assign w_div_step = {(w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], ~w_diff[WIDTH]};

  assign w_prod   = r_neg_lo ? -r_acc : r_acc;
  assign w_rem    = r_acc[2*WIDTH-1:WIDTH];
  assign w_quo    = r_acc[WIDTH-1:0];
  assign w_res_hi = r_is_div ? (r_neg_hi ? -w_rem : w_rem) : w_prod[2*WIDTH-1:WIDTH];
  assign w_res_lo = r_is_div ? (r_neg_lo ? -w_quo : w_quo) : w_prod[WIDTH-1:0];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_PREP;
      S_PREP:  w_next = (r_is_div && r_b == '0) ? S_FIX : S_RUN;
      S_RUN:   if (r_cnt == '0) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_is_div   <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_dz       <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a        <= i_a;
            r_b        <= i_b;
            r_is_div   <= i_op[0];
            r_div_zero <= 1'b0;
          end
        end
        S_PREP: begin
          r_dz     <= r_is_div && (r_b == '0);
          r_neg_lo <= w_a_neg ^ w_b_neg;
          r_neg_hi <= w_a_neg;
          r_a      <= w_mag_a;
          r_b      <= w_mag_b;
          r_acc    <= {{WIDTH{1'b0}}, (r_is_div ? w_mag_a : w_mag_b)};
          r_cnt    <= CW'(WIDTH - 1);
        end
        S_RUN: begin
          r_acc <= r_is_div ? w_div_step : w_mul_step;
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (r_dz) begin
            r_div_zero <= 1'b1;
          end else begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = r_done;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;
  assign o_div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random operations against a 64-bit arithmetic model.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo), .o_div_zero(dz)
  );

  always #5 clk = ~clk;

  // Reference: full-width arithmetic on 64-bit integers; returns {hi, lo}.
  function automatic logic [2*W-1:0] ref_op(input logic [1:0] f_op, input logic [W-1:0] fa, input logic [W-1:0] fb);
    logic uns;
    longint sa, sb, sq, sr;
    logic [W-1:0] uq, ur;
`ifdef MULDIV_UNSIGNED_EN
    uns = f_op[1];
`else
    uns = 1'b0;
`endif
    sa = longint'($signed(fa));
    sb = longint'($signed(fb));
    if (!f_op[0]) begin
      if (uns) return {{W{1'b0}}, fa} * {{W{1'b0}}, fb};
      return 64'(sa * sb);
    end
    if (uns) begin
      uq = fa / fb;
      ur = fa % fb;
      return {ur, uq};
    end
    sq = sa / sb;
    sr = sa % sb;
    return {sr[W-1:0], sq[W-1:0]};
  endfunction

  // Run one operation; latency counts edges after the accepting edge until done is seen.
  task automatic do_op(input logic [1:0] t_op, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       output int lat, output logic busy_ok, output logic dz_after_accept,
                       output logic done_next, output logic busy_at_done);
    @(negedge clk);
    if (done) @(negedge clk);
    start = 1'b1; op = t_op; a = ta; b = tb;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    lat = 0;
    busy_ok = busy;
    dz_after_accept = dz;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    busy_at_done = busy;
    @(posedge clk); #1;
    done_next = done;
    if (!(t_op[0] && tb == '0)) {exp_hi, exp_lo} = ref_op(t_op, ta, tb);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b exp=0", dz); end
    checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    int lat; logic bok, dza, dn, bad;
    do_op(2'b00, 32'd7, -32'sd3, lat, bok, dza, dn, bad);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL mul_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_7x-3 got=%h_%h exp=ffffffff_ffffffeb", hi, lo); end
    checks++; if (!bok || bad !== 1'b0) begin errors++; $display("FAIL mul_busy got_ok=%b at_done=%b exp=1/0", bok, bad); end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL done_pulse_width got=%b exp=0", dn); end
    do_op(2'b01, -32'sd7, 32'd2, lat, bok, dza, dn, bad);
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_-7/2 got=%h_%h exp=ffffffff_fffffffd", hi, lo); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL div_latency got=%0d exp=%0d", lat, LAT); end
    do_op(2'b01, 32'h80000000, 32'hFFFFFFFF, lat, bok, dza, dn, bad);
    checks++; if (hi !== 32'h0 || lo !== 32'h80000000 || dz !== 1'b0) begin errors++; $display("FAIL div_min/-1 got=%h_%h dz=%b exp=00000000_80000000 dz=0", hi, lo, dz); end
    do_op(2'b10, 32'hFFFFFFFF, 32'd2, lat, bok, dza, dn, bad);
`ifdef MULDIV_UNSIGNED_EN
    checks++; if (hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu got=%h_%h exp=00000001_fffffffe", hi, lo); end
`else
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL mult_op1 got=%h_%h exp=ffffffff_fffffffe", hi, lo); end
`endif
    do_op(2'b11, 32'hFFFFFFFF, 32'd2, lat, bok, dza, dn, bad);
`ifdef MULDIV_UNSIGNED_EN
    checks++; if (hi !== 32'h1 || lo !== 32'h7FFFFFFF) begin errors++; $display("FAIL divu got=%h_%h exp=00000001_7fffffff", hi, lo); end
`else
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'h0) begin errors++; $display("FAIL div_op1 got=%h_%h exp=ffffffff_00000000", hi, lo); end
`endif
  endtask

  task automatic test_div_zero();
    int lat; logic bok, dza, dn, bad;
    do_op(2'b01, 32'd5, 32'd2, lat, bok, dza, dn, bad);
    checks++; if (hi !== 32'd1 || lo !== 32'd2) begin errors++; $display("FAIL div_5/2 got=%h_%h exp=1_2", hi, lo); end
    do_op(2'b01, 32'd5, 32'd0, lat, bok, dza, dn, bad);
    checks++; if (lat !== 2) begin errors++; $display("FAIL dz_latency got=%0d exp=2", lat); end
    checks++; if (dz !== 1'b1 || hi !== 32'd1 || lo !== 32'd2) begin errors++; $display("FAIL dz_result got=%h_%h dz=%b exp=1_2 dz=1", hi, lo, dz); end
    do_op(2'b00, 32'd3, 32'd4, lat, bok, dza, dn, bad);
    checks++; if (dza !== 1'b0) begin errors++; $display("FAIL dz_clear_on_start got=%b exp=0", dza); end
    checks++; if (lo !== 32'd12 || hi !== 32'd0 || dz !== 1'b0) begin errors++; $display("FAIL after_dz got=%h_%h dz=%b exp=0_c dz=0", hi, lo, dz); end
  endtask

  task automatic test_ignored_start();
    int ndone, first_n;
    logic [W-1:0] ghi, glo;
    ndone = 0; first_n = 0; ghi = '0; glo = '0;
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd12345; b = 32'hFFFFFFF9;
    @(posedge clk); #1;
    start = 1'b0;
    {exp_hi, exp_lo} = ref_op(2'b00, 32'd12345, 32'hFFFFFFF9);
    for (int n = 1; n <= LAT + 8; n++) begin
      @(posedge clk); #1;
      if (n == 9) begin start = 1'b1; op = 2'b00; a = $urandom; b = $urandom; end
      if (n == 10) start = 1'b0;
      if (done) begin
        ndone++;
        if (first_n == 0) begin first_n = n; ghi = hi; glo = lo; end
      end
    end
    checks++; if (ndone !== 1 || first_n !== LAT) begin errors++; $display("FAIL ignored_start dones=%0d at=%0d exp=1 at %0d", ndone, first_n, LAT); end
    checks++; if (ghi !== exp_hi || glo !== exp_lo) begin errors++; $display("FAIL ignored_start_result got=%h_%h exp=%h_%h", ghi, glo, exp_hi, exp_lo); end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic bok, dza, dn, bad;
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = $urandom; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0 || hi !== '0 || lo !== '0)
      begin errors++; $display("FAIL reset_mid_run got busy=%b done=%b dz=%b hi=%h lo=%h exp all 0", busy, done, dz, hi, lo); end
    @(negedge clk); rst = 1'b0;
    exp_hi = '0; exp_lo = '0;
    do_op(2'b00, 32'hFFFF0000, 32'h00010001, lat, bok, dza, dn, bad);
    checks++; if (lat !== LAT || hi !== exp_hi || lo !== exp_lo)
      begin errors++; $display("FAIL after_reset_op lat=%0d got=%h_%h exp lat=%0d %h_%h", lat, hi, lo, LAT, exp_hi, exp_lo); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2; logic bok, dza, dn, bad;
    do_op(2'b01, 32'd100, 32'd7, lat1, bok, dza, dn, bad);
    do_op(2'b00, 32'd100, 32'd7, lat2, bok, dza, dn, bad);
    checks++; if (lat1 !== LAT || lat2 !== LAT) begin errors++; $display("FAIL back_to_back lat=%0d/%0d exp=%0d", lat1, lat2, LAT); end
    checks++; if (hi !== 32'd0 || lo !== 32'd700) begin errors++; $display("FAIL back_to_back_result got=%h_%h exp=0_2bc", hi, lo); end
  endtask

  task automatic test_random();
    int lat, exp_lat; logic bok, dza, dn, bad;
    logic [1:0] r_op; logic [W-1:0] ra, rb;
    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      exp_lat = (r_op[0] && rb == '0) ? 2 : LAT;
      do_op(r_op, ra, rb, lat, bok, dza, dn, bad);
      checks++;
      if (lat !== exp_lat || hi !== exp_hi || lo !== exp_lo || dz !== (r_op[0] && rb == '0) || dn !== 1'b0 || !bok) begin
        errors++;
        $display("FAIL random[%0d] op=%b a=%h b=%h got lat=%0d %h_%h dz=%b exp lat=%0d %h_%h", i, r_op, ra, rb, lat, hi, lo, dz, exp_lat, exp_hi, exp_lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
